// File: rtl/forwarding_ctrl.sv
// Operand forwarding and load-use hazard control for a 5-stage pipeline.
// Tracks the destination of the instructions in MEM and WB, and counts load-use stalls.
module forwarding_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  ex_rs1,
  input  logic [4:0]  ex_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_valid,
  input  logic        ex_regwrite,
  input  logic        ex_memread,
  input  logic        flush,
  output logic [1:0]  forward_a,
  output logic [1:0]  forward_b,
  output logic        stall,
  output logic [15:0] stall_count
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_WB  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  logic [4:0] mem_rd;
  logic       mem_wr;
  logic [4:0] wb_rd;
  logic       wb_wr;

  // MEM is checked first so the newer value wins; x0 is never a forwarding source.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic [4:0] m_rd,
    input logic       m_wr,
    input logic [4:0] w_rd,
    input logic       w_wr
  );
    if (m_wr && (m_rd != 5'd0) && (m_rd == src))
      return SEL_MEM;
    else if (w_wr && (w_rd != 5'd0) && (w_rd == src))
      return SEL_WB;
    else
      return SEL_RF;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // EX -> MEM -> WB destination tracking; advances even while stalling
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rd <= 5'd0;
      mem_wr <= 1'b0;
      wb_rd  <= 5'd0;
      wb_wr  <= 1'b0;
    end else begin
      mem_rd <= ex_rd;
      mem_wr <= ex_valid & ex_regwrite;
      wb_rd  <= mem_rd;
      wb_wr  <= mem_wr;
    end
  end

  always_comb begin
    forward_a = fwd_sel(ex_rs1, mem_rd, mem_wr, wb_rd, wb_wr);
    forward_b = fwd_sel(ex_rs2, mem_rd, mem_wr, wb_rd, wb_wr);
  end

  always_comb begin
    stall = ex_valid && ex_memread && ex_regwrite && (ex_rd != 5'd0) &&
            ((ex_rd == id_rs1) || (ex_rd == id_rs2)) && !flush;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_count <= 16'd0;
    else if (stall)
      stall_count <= sat_inc(stall_count);
  end

endmodule
